spram_port_arbiter: RTL
=======================

// Module: spram_port_arbiter
// PURPOSE
// Shares one single-port RAM between two requesters: port A (instruction fetch) and port B (data load/store).
// Grants at most one access per cycle, drives the RAM en/we/addr/wdata, and registers read data into per-port responses.
// Supports locked sequences so a read-modify-write (TAS.B) stays atomic against the other port.
// PARAMETERS
// ADDR_WIDTH       8    RAM word-address width
// DATA_WIDTH       32   RAM word width
// MAX_LOCK_CYCLES  16   max cycles a lock may be held before forced release (>=2)
// PORTS
// clk               in   1           clock, all state on posedge
// rst_n             in   1           async active-low reset
// {a,b}_req_valid   in   1           request present; addr/we/wdata/lock held stable until ready
// {a,b}_req_ready   out  1           grant this cycle (combinational); handshake = valid & ready
// {a,b}_req_we      in   1           1 = write, 0 = read
// {a,b}_req_lock    in   1           keep grant after this access
// {a,b}_req_addr    in   ADDR_WIDTH  word address
// {a,b}_req_wdata   in   DATA_WIDTH  write data
// {a,b}_rsp_valid   out  1           one-cycle pulse, one per handshake
// {a,b}_rsp_rdata   out  DATA_WIDTH  mem_rdata captured at handshake
// mem_en            out  1           = a_req_ready | b_req_ready
// mem_we            out  1           granted port's we, 0 when idle
// mem_addr          out  ADDR_WIDTH  granted port's addr, 0 when idle
// mem_wdata         out  DATA_WIDTH  granted port's wdata, 0 when idle
// mem_rdata         in   DATA_WIDTH  asynchronous RAM read data for mem_addr
// lock_err          out  1           one-cycle pulse on forced lock release
// BEHAVIOUR
// - Reset: state IDLE, last_grant=B, lock_cnt=0, all rsp_valid/rsp_rdata/lock_err = 0.
// - States: IDLE, LOCK_A, LOCK_B.
// - IDLE: one valid -> grant it. Both valid -> arbitration policy (see CONFIGURATION).
//   Handshake with lock=1 -> LOCK_x, lock_cnt=0. last_grant updates on every handshake.
// - LOCK_x: only x is grantable; other port ready=0.
//   x handshake with lock=0 -> IDLE after that access.
//   lock_cnt increments each LOCK cycle. lock_cnt==MAX_LOCK_CYCLES-1 with no releasing handshake -> IDLE, lock_err=1.
//   A handshake in that same cycle is still performed.
// - Latency: rsp_valid exactly 1 cycle after handshake, for reads and writes.
//   rsp_rdata = mem_rdata sampled in the handshake cycle, i.e. pre-write (old) data on writes.
// - Back-to-back: one handshake per port per cycle is allowed; rsp stream matches request order.
// - rsp_rdata holds its value while rsp_valid=0.
// - No address arithmetic; addresses pass through unmodified.
// - Reset mid-lock or mid-response: returns to IDLE; pending responses are dropped.
// CONFIGURATION
// SPRAM_ARB_ROUND_ROBIN_EN defined: on contention, grant the port != last_grant (A wins first after reset).
// Not defined: fixed priority, B (data) always beats A; last_grant is still tracked but unused.
// STRUCTURE
// Shared package sh_mem_pkg:
// - arb_state_e {IDLE, LOCK_A, LOCK_B}
// - port_id_e {PORT_A, PORT_B}
// - mem_req_t struct {we, lock, addr, wdata}, parameterised by the package ADDR_W/DATA_W constants.
// No sub-module: grant pick, lock timer and response registers are small enough to stay inline.
// TESTING
// 1 A reads 0x10 (mem=0xDEADBEEF) alone -> a_ready same cycle; a_rsp_valid next cycle, rdata 0xDEADBEEF; b_rsp_valid=0.
// 2 A and B both read 3 cycles, RR build -> grants A,B,A; fixed build -> B,B,B with A ready=0.
// 3 B lock-read 0x20 (old 0x00) then write 0xFF lock=0 while A valid -> A blocked 2 cycles; B rsp rdata 0x00 twice; then A granted.
// 4 B lock then idle 15 cycles (MAX=16) -> lock_err pulses once at lock_cnt=15; A granted next cycle.
// 5 rst_n low during LOCK_A with pending rsp -> all outputs 0 immediately; after release, single B request granted first cycle.
// 6 B write 0x30 = 0x1234 then A read 0x30 -> B rsp rdata = old value; A rsp rdata 0x1234.

Source files
------------

// File: rtl/sh_mem_pkg.sv
// Shared types for the single-port RAM arbiter: arbiter states, port ids
// and the request bundle layout.
package sh_mem_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } arb_state_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_e;

  typedef struct packed {
    logic              we;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/spram_port_arbiter.sv
// Two-port arbiter in front of one single-port RAM (A = fetch, B = data).
// One grant per cycle, locked sequences for atomic read-modify-write, and a
// lock timer that force-releases a stuck lock.
// Optional feature macro: SPRAM_ARB_ROUND_ROBIN_EN (round-robin on contention;
// otherwise B has fixed priority).
module spram_port_arbiter
  import sh_mem_pkg::*;
#(
  parameter int ADDR_WIDTH      = 8,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_LOCK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_we,
  input  logic                  a_req_lock,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  input  logic [DATA_WIDTH-1:0] a_req_wdata,
  output logic                  a_rsp_valid,
  output logic [DATA_WIDTH-1:0] a_rsp_rdata,
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic                  b_req_we,
  input  logic                  b_req_lock,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  input  logic [DATA_WIDTH-1:0] b_req_wdata,
  output logic                  b_rsp_valid,
  output logic [DATA_WIDTH-1:0] b_rsp_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  lock_err
);

  localparam int CNT_W = (MAX_LOCK_CYCLES > 2) ? $clog2(MAX_LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LOCK_CYCLES - 1);

  arb_state_e       state;
  port_id_e         last_grant;
  logic [CNT_W-1:0] lock_cnt;
  logic             own_lock;
  logic             lock_expire;

  // Ready is only raised toward a valid requester, so ready == handshake.
  // Grant pick: the lock owner exclusively, otherwise arbitrate on contention.
  always_comb begin
    a_req_ready = 1'b0;
    b_req_ready = 1'b0;
    unique case (state)
      LOCK_A: a_req_ready = a_req_valid;
      LOCK_B: b_req_ready = b_req_valid;
      default: begin
        if (a_req_valid && b_req_valid) begin
`ifdef SPRAM_ARB_ROUND_ROBIN_EN
          if (last_grant == PORT_B) a_req_ready = 1'b1;
          else                      b_req_ready = 1'b1;
`else
          b_req_ready = 1'b1;
`endif
        end else begin
          a_req_ready = a_req_valid;
          b_req_ready = b_req_valid;
        end
      end
    endcase
  end

  // RAM bus mux: granted port's fields, all-zero when idle.
  always_comb begin
    mem_en    = a_req_ready | b_req_ready;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (a_req_ready) begin
      mem_we    = a_req_we;
      mem_addr  = a_req_addr;
      mem_wdata = a_req_wdata;
    end else if (b_req_ready) begin
      mem_we    = b_req_we;
      mem_addr  = b_req_addr;
      mem_wdata = b_req_wdata;
    end
  end

  assign own_lock    = (state == LOCK_A) ? a_req_lock : b_req_lock;
  assign lock_expire = (lock_cnt == CNT_LAST);

  // Lock FSM, lock timer and last-grant tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= PORT_B;
      lock_cnt   <= '0;
      lock_err   <= 1'b0;
    end else begin
      lock_err <= 1'b0;
      if (a_req_ready)      last_grant <= PORT_A;
      else if (b_req_ready) last_grant <= PORT_B;
      unique case (state)
        LOCK_A, LOCK_B: begin
          // Only the owner can handshake here; a lock=0 access ends the
          // sequence, otherwise the timer may force the release.
          if ((a_req_ready || b_req_ready) && !own_lock) begin
            state <= IDLE;
          end else if (lock_expire) begin
            state    <= IDLE;
            lock_err <= 1'b1;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        default: begin
          if (a_req_ready && a_req_lock) begin
            state    <= LOCK_A;
            lock_cnt <= '0;
          end else if (b_req_ready && b_req_lock) begin
            state    <= LOCK_B;
            lock_cnt <= '0;
          end
        end
      endcase
    end
  end

  // Response registers: pulse one cycle after the handshake, data = RAM
  // contents seen during the handshake (old data for writes), held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
      a_rsp_rdata <= '0;
      b_rsp_rdata <= '0;
    end else begin
      a_rsp_valid <= a_req_ready;
      b_rsp_valid <= b_req_ready;
      if (a_req_ready) a_rsp_rdata <= mem_rdata;
      if (b_req_ready) b_rsp_rdata <= mem_rdata;
    end
  end

endmodule
